// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    // Reserved encoding 2'b11 behaves as a word access.
    function automatic mem_size_e decode_size(logic [1:0] raw);
        case (raw)
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(mem_size_e size, logic [1:0] lo);
        case (size)
            MEM_HALF: return lo[0];
            MEM_WORD: return lo != 2'b00;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_down(mem_size_e size, logic [1:0] lo);
        case (size)
            MEM_BYTE: return lo;
            MEM_HALF: return {lo[1], 1'b0};
            default:  return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(mem_size_e size, logic [1:0] lo);
        case (size)
            MEM_BYTE: return 4'b0001 << lo;
            MEM_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU datapath and the memory responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane merge for writes and lane extract/zero-extend for reads.
module mem_byte_lane
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  mem_size_e   size,
    input  logic [1:0]  lo,
    input  logic [3:0]  be,
    output logic [31:0] merged,
    output logic [31:0] rdata
);

    logic [31:0] lane_data;
    logic [31:0] shifted;

    always_comb begin
        // Replicate the right-justified data so every enabled lane sees it.
        case (size)
            MEM_BYTE: lane_data = {4{wdata[7:0]}};
            MEM_HALF: lane_data = {2{wdata[15:0]}};
            default:  lane_data = wdata;
        endcase

        merged = word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = lane_data[8*k +: 8];
            end
        end

        shifted = word >> {lo, 3'b000};
        case (size)
            MEM_BYTE: rdata = {24'h0, shifted[7:0]};
            MEM_HALF: rdata = {16'h0, shifted[15:0]};
            default:  rdata = shifted;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait states.
// Optional misalignment trap: define MEM_RESPONDER_MISALIGN_TRAP_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clock,
    input  logic            Reset_n,
    mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_W = IDX_W + 2;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                write_q;
    mem_size_e           size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                load_rsp;

    logic [31:0]         mem_q [DEPTH_WORDS];

    logic                idle;
    logic                accept;
    logic                cur_write;
    mem_size_e           cur_size;
    logic [ADDR_W-1:0]   cur_addr;
    logic [31:0]         cur_wdata;
    logic [IDX_W-1:0]    idx;
    logic                trap;
    logic [1:0]          eff_lo;
    logic [3:0]          be;
    logic [31:0]         lane_merged;
    logic [31:0]         lane_rdata;
    logic                mem_we;

    assign idle   = (state_q == IDLE);
    assign accept = idle && bus.req_valid;

    // With zero wait states the access happens on the accept edge itself, so use the bus directly.
    assign cur_write = idle ? bus.req_write                 : write_q;
    assign cur_size  = idle ? decode_size(bus.req_size)     : size_q;
    assign cur_addr  = idle ? bus.req_addr[ADDR_W-1:0]      : addr_q;
    assign cur_wdata = idle ? bus.req_wdata                 : wdata_q;
    assign idx       = cur_addr[ADDR_W-1:2];

`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    assign trap   = is_misaligned(cur_size, cur_addr[1:0]);
    assign eff_lo = cur_addr[1:0];
`else
    assign trap   = 1'b0;
    assign eff_lo = align_down(cur_size, cur_addr[1:0]);
`endif

    assign be = byte_enable(cur_size, eff_lo);

    mem_byte_lane u_lane (
        .word   (mem_q[idx]),
        .wdata  (cur_wdata),
        .size   (cur_size),
        .lo     (eff_lo),
        .be     (be),
        .merged (lane_merged),
        .rdata  (lane_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        load_rsp = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_d  = RESP;
                        load_rsp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = RESP;
                    load_rsp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (load_rsp) begin
            err_d   = trap;
            rdata_d = (cur_write || trap) ? 32'h0 : lane_rdata;
        end
    end

    // Reset gates the commit so an aborted access can never land in storage.
    assign mem_we = load_rsp && cur_write && !trap && Reset_n;

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            size_q  <= MEM_BYTE;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= bus.req_write;
                size_q  <= decode_size(bus.req_size);
                addr_q  <= bus.req_addr[ADDR_W-1:0];
                wdata_q <= bus.req_wdata;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx] <= lane_merged;
        end
    end

    assign bus.req_ready = idle;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: dut_a (LATENCY=2) and dut_b (LATENCY=0) share request fields, separate valids.
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        Reset_n;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t qa[$];
    exp_t qb[$];

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    assign bus_a.req_valid = req_valid & ~sel;
    assign bus_b.req_valid = req_valid & sel;
    assign bus_a.req_write = req_write;
    assign bus_b.req_write = req_write;
    assign bus_a.req_size  = req_size;
    assign bus_b.req_size  = req_size;
    assign bus_a.req_addr  = req_addr;
    assign bus_b.req_addr  = req_addr;
    assign bus_a.req_wdata = req_wdata;
    assign bus_b.req_wdata = req_wdata;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
        .clock   (clock),
        .Reset_n (Reset_n),
        .bus     (bus_a)
    );

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
        .clock   (clock),
        .Reset_n (Reset_n),
        .bus     (bus_b)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (Reset_n && bus_a.rsp_valid) begin
            if (qa.size() == 0) begin
                check("a_unexpected_rsp", {31'b0, bus_a.rsp_valid}, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_rdata", bus_a.rsp_rdata, e.rdata);
                check("a_err", {31'b0, bus_a.rsp_err}, {31'b0, e.err});
                check("a_latency", cyc, e.due);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (Reset_n && bus_b.rsp_valid) begin
            if (qb.size() == 0) begin
                check("b_unexpected_rsp", {31'b0, bus_b.rsp_valid}, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_rdata", bus_b.rsp_rdata, e.rdata);
                check("b_err", {31'b0, bus_b.rsp_err}, {31'b0, e.err});
                check("b_latency", cyc, e.due);
            end
        end
    end

    // Issue one request, wait for the accept edge, and queue the expected response.
    task automatic issue(input bit s, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e,
                         input bit push);
        int   n = 0;
        logic rdy;
        exp_t e;
        @(negedge clock);
        sel       = s;
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        rdy = s ? bus_b.req_ready : bus_a.req_ready;
        while (!rdy && n < 50) begin
            @(negedge clock);
            n++;
            rdy = s ? bus_b.req_ready : bus_a.req_ready;
        end
        check("ready_wait", {31'b0, rdy}, 32'd1);
        if (!rdy) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        e.rdata = exp_d;
        e.err   = exp_e;
        e.due   = cyc + (s ? 0 : 2) + 1;
        if (push) begin
            if (s) qb.push_back(e);
            else   qa.push_back(e);
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("drain", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   accepts;
        logic r;
        exp_t e;
        Reset_n   = 1'b0;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h0;
        req_wdata = 32'h0;

        #3;
        check("rst_ready_a", {31'b0, bus_a.req_ready}, 32'd1);
        check("rst_valid_a", {31'b0, bus_a.rsp_valid}, 32'd0);
        check("rst_rdata_a", bus_a.rsp_rdata, 32'h0);
        check("rst_err_a", {31'b0, bus_a.rsp_err}, 32'd0);
        check("rst_ready_b", {31'b0, bus_b.req_ready}, 32'd1);
        @(negedge clock);
        Reset_n = 1'b1;

        // Reset mid-WAIT discards the pending write.
        issue(0, 1, 2'b10, 32'h10, 32'h5555AAAA, 32'h0, 0, 1);
        issue(0, 1, 2'b10, 32'h10, 32'hFFFFFFFF, 32'h0, 0, 0);
        Reset_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, bus_a.req_ready}, 32'd1);
        check("midrst_valid", {31'b0, bus_a.rsp_valid}, 32'd0);
        @(negedge clock);
        Reset_n = 1'b1;
        issue(0, 0, 2'b10, 32'h10, 32'h0, 32'h5555AAAA, 0, 1);

        // Word write/read.
        issue(0, 1, 2'b10, 32'h40, 32'hDEADBEEF, 32'h0, 0, 1);
        issue(0, 0, 2'b10, 32'h40, 32'h0, 32'hDEADBEEF, 0, 1);

        // Byte/half lanes.
        issue(0, 1, 2'b10, 32'h80, 32'h11223344, 32'h0, 0, 1);
        issue(0, 1, 2'b00, 32'h81, 32'hFFFFFFAA, 32'h0, 0, 1);
        issue(0, 0, 2'b10, 32'h80, 32'h0, 32'h1122AA44, 0, 1);
        issue(0, 0, 2'b01, 32'h82, 32'h0, 32'h00001122, 0, 1);
        issue(0, 0, 2'b00, 32'h83, 32'h0, 32'h00000011, 0, 1);
        issue(0, 0, 2'b11, 32'h80, 32'h0, 32'h1122AA44, 0, 1);
        drain();

        // Busy: valid held high for 8 cycles -> accepts every LATENCY+2 cycles.
        accepts = 0;
        @(negedge clock);
        sel       = 1'b0;
        req_write = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h40;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clock);
            r = bus_a.req_ready;
            @(posedge clock);
            if (r) begin
                e.rdata = 32'hDEADBEEF;
                e.err   = 1'b0;
                e.due   = cyc + 3;
                qa.push_back(e);
                accepts++;
            end
        end
        @(negedge clock);
        req_valid = 1'b0;
        check("busy_accepts", 32'(accepts), 32'd2);
        drain();

        // Misalignment.
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
        issue(0, 0, 2'b10, 32'h42, 32'h0, 32'h0, 1, 1);
        issue(0, 1, 2'b01, 32'h41, 32'h00001234, 32'h0, 1, 1);
        issue(0, 0, 2'b10, 32'h40, 32'h0, 32'hDEADBEEF, 0, 1);
`else
        issue(0, 0, 2'b10, 32'h42, 32'h0, 32'hDEADBEEF, 0, 1);
        issue(0, 1, 2'b01, 32'h41, 32'h00001234, 32'h0, 0, 1);
        issue(0, 0, 2'b10, 32'h40, 32'h0, 32'hDEAD1234, 0, 1);
`endif

        // Wrap-around aliasing and zero wait states.
        issue(1, 1, 2'b10, 32'h400, 32'hCAFEF00D, 32'h0, 0, 1);
        issue(1, 0, 2'b10, 32'h000, 32'h0, 32'hCAFEF00D, 0, 1);
        issue(1, 0, 2'b00, 32'h003, 32'h0, 32'h000000CA, 0, 1);
        issue(1, 0, 2'b01, 32'h402, 32'h0, 32'h0000CAFE, 0, 1);
        drain();

        repeat (3) @(negedge clock);
        check("idle_rdata_a", bus_a.rsp_rdata, 32'h0);
        check("idle_rdata_b", bus_b.rsp_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
